// File: rtl/rs_drive_pkg.sv
// Shared definitions for the rs_drive push-button-to-RS-latch driver:
// FSM state encoding and the counter-width helper.
package rs_drive_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    RST_P = 2'd2,
    GAP   = 2'd3
  } rs_state_t;

  localparam int SYNC_STAGES = 2;

  // Bits needed to hold values 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rs_debounce.sv
// One raw button channel: 2-flop synchroniser, stability-count debounce,
// and a registered one-cycle pulse on each debounced 0->1 change.
module rs_debounce
  import rs_drive_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   deb_reg;
  logic                   deb_d_reg;
  logic                   rise_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      deb_reg   <= 1'b0;
      deb_d_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], raw};
      deb_d_reg <= deb_reg;
      rise_reg  <= deb_reg & ~deb_d_reg;
      // Any agreement with the current debounced level restarts qualification.
      if (sync_reg[SYNC_STAGES-1] == deb_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg >= DEB_LAST) begin
        deb_reg <= sync_reg[SYNC_STAGES-1];
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/rs_drive.sv
// Turns two bouncing push buttons into non-overlapping, fixed-width s/r
// pulses for a downstream RS flip-flop, with one-deep request queueing.
module rs_drive
  import rs_drive_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_raw,
  input  logic rst_raw,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int PW = cnt_w(PULSE_CYCLES);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

  logic [1:0] raw_vec;
  logic [1:0] rise_vec;

  assign raw_vec = {rst_raw, set_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      rs_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (raw_vec[gi]),
        .rise (rise_vec[gi])
      );
    end
  endgenerate

  rs_state_t     state_reg, state_next;
  logic [PW-1:0] pcnt_reg, pcnt_next;
  logic          set_pend_reg, set_pend_next;
  logic          rst_pend_reg, rst_pend_next;
  logic          pair_reg, pair_next;
  logic          conflict_next;
  logic          s_reg, r_reg, conflict_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pcnt_reg     <= '0;
      set_pend_reg <= 1'b0;
      rst_pend_reg <= 1'b0;
      pair_reg     <= 1'b0;
      s_reg        <= 1'b0;
      r_reg        <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pcnt_reg     <= pcnt_next;
      set_pend_reg <= set_pend_next;
      rst_pend_reg <= rst_pend_next;
      pair_reg     <= pair_next;
      s_reg        <= (state_next == SET_P);
      r_reg        <= (state_next == RST_P);
      conflict_reg <= conflict_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pcnt_next     = pcnt_reg;
    set_pend_next = set_pend_reg | rise_vec[0];
    rst_pend_next = rst_pend_reg | rise_vec[1];
    // pair marks two requests that became pending on the very same edge.
    pair_next     = pair_reg | (rise_vec[0] & rise_vec[1] & ~set_pend_reg & ~rst_pend_reg);
    conflict_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (set_pend_reg && rst_pend_reg && pair_reg) begin
          set_pend_next = 1'b0;
          rst_pend_next = 1'b0;
          pair_next     = 1'b0;
          conflict_next = 1'b1;
        end else if (set_pend_reg) begin
          state_next    = SET_P;
          set_pend_next = 1'b0;
          pcnt_next     = '0;
        end else if (rst_pend_reg) begin
          state_next    = RST_P;
          rst_pend_next = 1'b0;
          pcnt_next     = '0;
        end
      end
      SET_P, RST_P: begin
        if (pcnt_reg >= PULSE_LAST) begin
          state_next = GAP;
          pcnt_next  = '0;
        end else begin
          pcnt_next = pcnt_reg + 1'b1;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign s        = s_reg;
  assign r        = r_reg;
  assign conflict = conflict_reg;
  assign busy     = (state_reg != IDLE);

endmodule
